// File: rtl/ifmap_noc.sv
// ifmap_noc: latches one IFMAP tile and streams it, diagonal by
// diagonal, onto an 80-bit broadcast bus feeding the 6x7 PE array.
// Ports: clk, rst (async, active-high); start, start_conv,
//   layer_type_in, mode_in, conv_complete, ifmap_data_in,
//   ifmap_data_valid_in, pe_full, complete_count in;
//   pe_calculation_complete, free_ifmap_buffer, diagonal_bus_packet out.
// Option: NOC_ZERO_SKIP_EN drops all-zero beats from the stream.
module ifmap_noc #(
  parameter int NUM_ROWS  = 35,
  parameter int ROW_BYTES = 256,
  parameter int PE_ROWS   = 6,
  parameter int PE_COLS   = 7,
  parameter int N_DIAG    = 12,
  parameter int BEAT_BITS = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 start_conv,
  input  logic [1:0]                           layer_type_in,
  input  logic [1:0]                           mode_in,
  input  logic                                 conv_complete,
  input  logic [NUM_ROWS-1:0][ROW_BYTES*8-1:0] ifmap_data_in,
  input  logic                                 ifmap_data_valid_in,
  input  logic [PE_ROWS-1:0][PE_COLS-1:0]      pe_full,
  input  logic [4:0]                           complete_count,
  output logic                                 pe_calculation_complete,
  output logic                                 free_ifmap_buffer,
  output logic [79:0]                          diagonal_bus_packet
);

  localparam int BEATS = ROW_BYTES * 8 / BEAT_BITS;
  localparam int SLOTS = N_DIAG * BEATS;

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, LOADED, SEND, WAIT_PE, DONE
  } state_t;

  state_t state, state_n;
  logic fc, fc_n, cont, cont_n, load, emit;
  logic [5:0] base, base_n;
  logic [8:0] cur, cur_n;
  logic [NUM_ROWS-1:0][ROW_BYTES*8-1:0] tile;
  logic [N_DIAG-1:0] diag_full;
  logic [5:0] s_base, hrow;
  logic [9:0] s_from, hit, nxt;
  logic [3:0] hd;
  logic [4:0] hb;
  logic [BEAT_BITS-1:0] hdata;
  logic [79:0] pkt_n;
  logic pcc_n, free_n;

`ifdef NOC_ZERO_SKIP_EN
  logic [NUM_ROWS-1:0][BEATS-1:0] row_nz;

  always_comb begin
    row_nz = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int b = 0; b < BEATS; b++)
        row_nz[r][b] = |tile[r][b*BEAT_BITS +: BEAT_BITS];
  end
`endif

  // A slot (diag, beat) is sendable when its row exists in the tile
  // (and, with zero skip, when its beat carries any set bit).
  function automatic logic ok(input logic [5:0] fbase, input int i);
    logic [5:0] row;
    row = fbase + 6'(i / BEATS);
`ifdef NOC_ZERO_SKIP_EN
    return (row <= 6'(NUM_ROWS-1)) && row_nz[row][i % BEATS];
`else
    return row <= 6'(NUM_ROWS-1);
`endif
  endfunction

  // First sendable slot at or after 'from': {found, diag, beat}.
  function automatic logic [9:0] find(input logic [5:0] fbase,
                                      input logic [9:0] from);
    logic [9:0] r;
    r = '0;
    for (int i = SLOTS-1; i >= 0; i--)
      if (10'(i) >= from && ok(fbase, i)) r = {1'b1, 9'(i)};
    return r;
  endfunction

  always_comb begin
    diag_full = '0;
    for (int r = 0; r < PE_ROWS; r++)
      for (int c = 0; c < PE_COLS; c++)
        diag_full[r+c] = diag_full[r+c] | pe_full[r][c];
  end

  // The pass is launched straight from LOADED so the first beat
  // leaves on the edge that samples start_conv.
  always_comb begin
    s_base = base;
    s_from = {1'b0, cur};
    if (state == LOADED) begin
      s_base = '0;
      s_from = '0;
    end
    hit = find(s_base, s_from);
    nxt = find(s_base, {1'b0, hit[8:0]} + 10'd1);
    hd = hit[8:5];
    hb = hit[4:0];
    hrow = s_base + {2'b0, hd};
    hdata = tile[hrow][32'(hb) * BEAT_BITS +: BEAT_BITS];
  end

  always_comb begin
    state_n = state;
    fc_n = fc;
    cont_n = cont;
    base_n = base;
    cur_n = cur;
    load = 1'b0;
    emit = 1'b0;
    pkt_n = '0;
    pcc_n = 1'b0;
    free_n = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        fc_n = (layer_type_in == 2'd1);
        cont_n = (mode_in == 2'd1);
        state_n = WAIT_DATA;
      end
      WAIT_DATA:
        if (conv_complete) begin
          free_n = 1'b1;
          state_n = IDLE;
        end else if (ifmap_data_valid_in) begin
          load = 1'b1;
          state_n = LOADED;
        end
      LOADED:
        if (conv_complete) begin
          free_n = 1'b1;
          state_n = IDLE;
        end else if (start_conv) begin
          base_n = '0;
          emit = 1'b1;
        end
      SEND:
        if (conv_complete) begin
          free_n = 1'b1;
          state_n = IDLE;
        end else begin
          emit = 1'b1;
        end
      WAIT_PE:
        if (conv_complete) begin
          free_n = 1'b1;
          state_n = IDLE;
        end else if (complete_count >= 5'(PE_COLS)) begin
          pcc_n = 1'b1;
          if (fc || !cont ||
              ({1'b0, base} + 7'(PE_COLS)) > 7'(NUM_ROWS-1)) begin
            state_n = DONE;
          end else begin
            base_n = base + 6'(PE_COLS);
            cur_n = '0;
            state_n = SEND;
          end
        end
      DONE: if (conv_complete) begin
        free_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (emit) begin
      if (!hit[9]) begin
        state_n = WAIT_PE;
      end else if (diag_full[hd]) begin
        cur_n = hit[8:0];
        state_n = SEND;
      end else begin
        pkt_n = {1'b1, hd, hrow, hb, hdata};
        cur_n = nxt[8:0];
        state_n = nxt[9] ? SEND : WAIT_PE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fc <= 1'b0;
      cont <= 1'b0;
      base <= '0;
      cur <= '0;
      diagonal_bus_packet <= '0;
      pe_calculation_complete <= 1'b0;
      free_ifmap_buffer <= 1'b0;
    end else begin
      state <= state_n;
      fc <= fc_n;
      cont <= cont_n;
      base <= base_n;
      cur <= cur_n;
      diagonal_bus_packet <= pkt_n;
      pe_calculation_complete <= pcc_n;
      free_ifmap_buffer <= free_n;
    end
  end

  always_ff @(posedge clk)
    if (load) tile <= ifmap_data_in;

endmodule

// File: tb/tb_ifmap_noc.sv
// tb_ifmap_noc: random-tile bench for ifmap_noc with a queue-based
// reference of the expected diagonal stream.
module tb_ifmap_noc;

  localparam int NR = 35;
  localparam int RB = 2048;
  typedef logic [NR-1:0][RB-1:0] tile_t;

  logic clk = 1'b0;
  logic rst;
  logic start, start_conv, conv_complete, ifmap_data_valid_in;
  logic [1:0] layer_type_in, mode_in;
  tile_t ifmap_data_in;
  logic [5:0][6:0] pe_full;
  logic [4:0] complete_count;
  logic pcc, free_buf;
  logic [79:0] pkt;

  int n_cmp = 0;
  int n_bad = 0;
  tile_t tile_cur;
  logic [79:0] expq[$];

  always #5 clk = ~clk;

  ifmap_noc dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_conv(start_conv),
    .layer_type_in(layer_type_in),
    .mode_in(mode_in),
    .conv_complete(conv_complete),
    .ifmap_data_in(ifmap_data_in),
    .ifmap_data_valid_in(ifmap_data_valid_in),
    .pe_full(pe_full),
    .complete_count(complete_count),
    .pe_calculation_complete(pcc),
    .free_ifmap_buffer(free_buf),
    .diagonal_bus_packet(pkt)
  );

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic tile_t rand_tile(input int zpct);
    tile_t t;
    for (int r = 0; r < NR; r++) begin
      for (int w = 0; w < RB/32; w++) t[r][w*32 +: 32] = $urandom;
      for (int b = 0; b < 32; b++)
        if ($urandom_range(0, 99) < zpct) t[r][b*64 +: 64] = '0;
    end
    return t;
  endfunction

  function automatic logic blocked(input logic [5:0][6:0] pf,
                                   input int d);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (r + c == d && pf[r][c]) return 1'b1;
    return 1'b0;
  endfunction

  // Expected beats of one pass: rows base..base+11 that exist.
  function automatic void build(input int base);
    logic [63:0] data;
    int row;
    expq.delete();
    for (int d = 0; d < 12; d++) begin
      row = base + d;
      if (row > NR - 1) break;
      for (int b = 0; b < 32; b++) begin
        data = tile_cur[row][b*64 +: 64];
`ifdef NOC_ZERO_SKIP_EN
        if (data == 64'd0) continue;
`endif
        expq.push_back({1'b1, 4'(d), 6'(row), 5'(b), data});
      end
    end
  endfunction

  // stall: 0 none, 1 pe_full[2][3] for 5 cycles mid diag 5, 2 random
  task automatic do_pass(input int base, input int stall,
                         input int abort_after);
    int popped = 0;
    int zeros = 0;
    int left = 5;
    int cyc = 0;
    logic ev;
    build(base);
    while (expq.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_conv = 1'b0;
      complete_count = '0;
      ev = !blocked(pe_full, int'(expq[0][78:75]));
      chk("valid", 80'(pkt[79]), 80'(ev));
      if (pkt[79]) begin
        chk("beat", pkt, expq[0]);
        void'(expq.pop_front());
        popped++;
      end else begin
        zeros++;
      end
      pe_full = '0;
      if (abort_after >= 0 && popped == abort_after) begin
        conv_complete = 1'b1;
        return;
      end
      if (stall == 1 && popped >= 170 && left > 0) begin
        pe_full[2][3] = 1'b1;
        left--;
      end
      if (stall == 2 && $urandom_range(0, 3) == 0)
        pe_full[$urandom_range(0, 5)][$urandom_range(0, 6)] = 1'b1;
    end
    pe_full = '0;
    chk("pass_left", 80'(expq.size()), 80'(0));
    if (stall == 1) chk("stall_cycles", 80'(zeros), 80'(5));
  endtask

  task automatic finish_pass();
    @(negedge clk);
    chk("wait_pe_pkt", pkt, 80'(0));
    complete_count = 5'($urandom_range(0, 6));
    @(negedge clk);
    chk("pcc_low", 80'(pcc), 80'(0));
    complete_count = 5'($urandom_range(7, 31));
    @(negedge clk);
    chk("pcc_pulse", 80'(pcc), 80'(1));
    complete_count = '0;
  endtask

  task automatic quiet(input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_conv = 1'b0;
      ifmap_data_valid_in = 1'b0;
      if (pkt[79] || pcc) cnt++;
    end
    chk("quiet", 80'(cnt), 80'(0));
  endtask

  task automatic end_layer();
    @(negedge clk);
    conv_complete = 1'b1;
    @(negedge clk);
    conv_complete = 1'b0;
    chk("free_pulse", 80'(free_buf), 80'(1));
    @(negedge clk);
    chk("free_low", 80'(free_buf), 80'(0));
  endtask

  task automatic arm(input logic [1:0] lt, input logic [1:0] md,
                     input tile_t t);
    @(negedge clk);
    start = 1'b1;
    layer_type_in = lt;
    mode_in = md;
    @(negedge clk);
    start = 1'b0;
    layer_type_in = 2'($urandom);
    mode_in = 2'($urandom);
    ifmap_data_in = t;
    tile_cur = t;
    ifmap_data_valid_in = 1'b1;
    @(negedge clk);
    ifmap_data_valid_in = 1'b0;
  endtask

  initial begin
    tile_t tz;
    rst = 1'b1;
    start = 1'b0;
    start_conv = 1'b0;
    conv_complete = 1'b0;
    ifmap_data_valid_in = 1'b0;
    layer_type_in = '0;
    mode_in = '0;
    ifmap_data_in = '0;
    pe_full = '0;
    complete_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_pkt", pkt, 80'(0));
    chk("rst_pcc", 80'(pcc), 80'(0));
    chk("rst_free", 80'(free_buf), 80'(0));
    rst = 1'b0;

    start_conv = 1'b1;
    ifmap_data_valid_in = 1'b1;
    quiet(4);

    arm(2'd1, 2'd1, rand_tile(10));
    ifmap_data_in = rand_tile(0);
    ifmap_data_valid_in = 1'b1;
    @(negedge clk);
    ifmap_data_valid_in = 1'b0;
    start_conv = 1'b1;
    do_pass(0, 0, -1);
    finish_pass();
    quiet(5);
    end_layer();

    arm(2'd0, 2'd1, rand_tile(0));
    start_conv = 1'b1;
    for (int p = 0; p < 5; p++) begin
      do_pass(7 * p, (p == 0) ? 1 : ((p == 2) ? 2 : 0), -1);
      finish_pass();
    end
    quiet(5);
    end_layer();

    arm(2'd0, 2'd2, rand_tile(20));
    start_conv = 1'b1;
    do_pass(0, 2, -1);
    finish_pass();
    quiet(5);
    end_layer();

    arm(2'd0, 2'd1, rand_tile(0));
    start_conv = 1'b1;
    do_pass(0, 0, 50);
    @(negedge clk);
    conv_complete = 1'b0;
    chk("abort_free", 80'(free_buf), 80'(1));
    chk("abort_pkt", pkt, 80'(0));
    @(negedge clk);
    chk("abort_free_low", 80'(free_buf), 80'(0));
    start_conv = 1'b1;
    quiet(4);

    tz = rand_tile(0);
    tz[0][63:0] = 64'h1;
    for (int r = 1; r < 12; r++) tz[r] = '0;
    arm(2'd1, 2'd0, tz);
    start_conv = 1'b1;
    do_pass(0, 0, -1);
    finish_pass();
    end_layer();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
